counter_reg_n: RTL and testbench

- Parametrised successor to the fixed 8-bit counter/output-register pair used on the board top level.
- Integrates its own clock-enable prescaler, so no separate clock divider is needed.
- Adds N-bit width, programmable terminal value, up/down counting, wrap/saturate/one-shot modes, and a cascade carry.
- Everything runs on one clock domain; the output register is loaded by a strobe instead of a second clock.

---
 rtl/counter_reg_n.sv | 117 +++++++++++
 tb/tb_counter_reg_n.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/counter_reg_n.sv
// counter_reg_n: N-bit up/down counter with a built-in clock-enable prescaler.
// It has three terminal modes (wrap, saturate, one-shot), a cascade carry and
// a strobe-loaded output register. Everything runs on the single clk domain.
module counter_reg_n #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_VALUE = 255,
  parameter int unsigned DIV_VALUE = 5000000
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  input  logic             cken,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  input  logic             store,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] data,
  output logic             tc,
  output logic             rco,
  output logic             done,
  output logic             tick,
  output logic             cled
);

  // DIV_VALUE=1 degenerates to a 1-bit divider stuck at 0, which gives tick=1 every cycle
  localparam int unsigned      DIV_W    = (DIV_VALUE > 1) ? $clog2(DIV_VALUE) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_VALUE - 1);
  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_WRAP_X  = 2'b11
  } mode_e;

  logic [DIV_W-1:0] div_q, div_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic             cled_q, cled_d;

  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] step_val;
  logic             frozen;
  logic             step;
  mode_e            mode_e_w;

  assign mode_e_w = mode_e'(mode);

  // Prescaler: free-running divider, tick on its last state, heartbeat LED toggles per tick
  always_comb begin
    tick   = (div_q == DIV_LAST);
    div_d  = tick ? '0 : div_q + DIV_W'(1);
    cled_d = cled_q ^ tick;
  end

  // Terminal detection, load clamp and step enable
  always_comb begin
    term     = up_dn ? MAX_V : '0;
    tc       = (cnt_q == term);
    rco      = tc & tick & cken;
    load_val = (data_in > MAX_V) ? MAX_V : data_in;
    frozen   = (mode_e_w == MODE_ONESHOT) & done_q;
    step     = tick & cken & ~load & ~frozen;
    step_val = up_dn ? cnt_q + ONE : cnt_q - ONE;
  end

  // Next-state for count, done and the stored output register
  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    data_d = store ? cnt_q : data_q;   // always samples the pre-edge count
    if (load) begin
      cnt_d  = load_val;
      done_d = 1'b0;
    end else if (step) begin
      if (tc) begin
        unique case (mode_e_w)
          MODE_SAT:     cnt_d = cnt_q;
          MODE_ONESHOT: done_d = 1'b1;
          default:      cnt_d = up_dn ? '0 : MAX_V;   // wrap, and 11 aliases wrap
        endcase
      end else begin
        cnt_d = step_val;
        // one-shot completes on the step that lands on the terminal value
        if (mode_e_w == MODE_ONESHOT && step_val == term) done_d = 1'b1;
      end
    end
  end

  // State registers, asynchronously cleared
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      div_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      done_q <= 1'b0;
      cled_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      done_q <= done_d;
      cled_q <= cled_d;
    end
  end

  assign cnt  = cnt_q;
  assign data = data_q;
  assign done = done_q;
  assign cled = cled_q;

endmodule

// File: tb/tb_counter_reg_n.sv
// Directed bench for counter_reg_n: prescaler, wrap/saturate/one-shot,
// load clamp/priority, store timing and a two-stage cascade.
module tb_counter_reg_n;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // prescaler instance: DIV_VALUE=4
  logic [7:0] p_din, p_cnt, p_data;
  logic       p_load, p_cken, p_up, p_store, p_tc, p_rco, p_done, p_tick, p_cled;
  logic [1:0] p_mode;

  // main function instance: MAX_VALUE=9, DIV_VALUE=1
  logic [7:0] a_din, a_cnt, a_data;
  logic       a_load, a_cken, a_up, a_store, a_tc, a_rco, a_done, a_tick, a_cled;
  logic [1:0] a_mode;

  // cascade pair: WIDTH=4, MAX_VALUE=15, DIV_VALUE=1
  logic [3:0] c0_din, c0_cnt, c0_data, c1_din, c1_cnt, c1_data;
  logic       c0_load, c0_cken, c0_tc, c0_rco, c0_done, c0_tick, c0_cled;
  logic       c1_load, c1_tc, c1_rco, c1_done, c1_tick, c1_cled;

  counter_reg_n #(.WIDTH(8), .MAX_VALUE(255), .DIV_VALUE(4)) u_pre (
    .clk(clk), .clr(clr), .data_in(p_din), .load(p_load), .cken(p_cken),
    .up_dn(p_up), .mode(p_mode), .store(p_store), .cnt(p_cnt), .data(p_data),
    .tc(p_tc), .rco(p_rco), .done(p_done), .tick(p_tick), .cled(p_cled));

  counter_reg_n #(.WIDTH(8), .MAX_VALUE(9), .DIV_VALUE(1)) u_a (
    .clk(clk), .clr(clr), .data_in(a_din), .load(a_load), .cken(a_cken),
    .up_dn(a_up), .mode(a_mode), .store(a_store), .cnt(a_cnt), .data(a_data),
    .tc(a_tc), .rco(a_rco), .done(a_done), .tick(a_tick), .cled(a_cled));

  counter_reg_n #(.WIDTH(4), .MAX_VALUE(15), .DIV_VALUE(1)) u_c0 (
    .clk(clk), .clr(clr), .data_in(c0_din), .load(c0_load), .cken(c0_cken),
    .up_dn(1'b1), .mode(2'b00), .store(1'b0), .cnt(c0_cnt), .data(c0_data),
    .tc(c0_tc), .rco(c0_rco), .done(c0_done), .tick(c0_tick), .cled(c0_cled));

  counter_reg_n #(.WIDTH(4), .MAX_VALUE(15), .DIV_VALUE(1)) u_c1 (
    .clk(clk), .clr(clr), .data_in(c1_din), .load(c1_load), .cken(c0_rco),
    .up_dn(1'b1), .mode(2'b00), .store(1'b0), .cnt(c1_cnt), .data(c1_data),
    .tc(c1_tc), .rco(c1_rco), .done(c1_done), .tick(c1_tick), .cled(c1_cled));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1;
    p_din = '0; p_load = 0; p_cken = 0; p_up = 0; p_mode = 2'b00; p_store = 0;
    a_din = '0; a_load = 0; a_cken = 0; a_up = 0; a_mode = 2'b00; a_store = 0;
    c0_din = '0; c0_load = 0; c0_cken = 0; c1_din = '0; c1_load = 0;
    #12;
    chk("rst_cnt",  32'(p_cnt),  32'h0);
    chk("rst_data", 32'(p_data), 32'h0);
    chk("rst_done", 32'(a_done), 32'h0);
    chk("rst_cled", 32'(p_cled), 32'h0);

    // prescaler: tick at cycles 3,7,11 after release
    p_cken = 1; p_up = 1; clr = 1'b0;
    #1 chk("pre_tick0", 32'(p_tick), 32'h0);
    for (int i = 1; i <= 12; i++) begin
      cyc();
      chk("pre_tick", 32'(p_tick), 32'((i % 4) == 3));
      chk("pre_cnt",  32'(p_cnt),  32'(i / 4));
      chk("pre_cled", 32'(p_cled), 32'((i / 4) % 2));
    end
    clr = 1'b1;
    #1;
    chk("clr_cnt",  32'(p_cnt),  32'h0);
    chk("clr_cled", 32'(p_cled), 32'h0);
    chk("clr_tick", 32'(p_tick), 32'h0);

    // load with tick=0/cken=0 on the prescaled instance; wrap-up on u_a
    p_cken = 0; p_load = 1; p_din = 8'h5A;
    a_load = 1; a_din = 8'd8; a_up = 1; a_cken = 1; a_mode = 2'b00;
    clr = 1'b0;
    #1 chk("pre_ld_tick", 32'(p_tick), 32'h0);
    cyc();
    chk("pre_ld_cnt", 32'(p_cnt), 32'h5A);
    chk("wrap_ld8",   32'(a_cnt), 32'd8);
    chk("wrap_tc8",   32'(a_tc),  32'h0);
    p_load = 0; a_load = 0;
    cyc(); chk("wrap_9", 32'(a_cnt), 32'd9); chk("wrap_tc9", 32'(a_tc), 32'h1);
    chk("wrap_rco9", 32'(a_rco), 32'h1);
    cyc(); chk("wrap_0", 32'(a_cnt), 32'd0); chk("wrap_tc0", 32'(a_tc), 32'h0);
    cyc(); chk("wrap_1", 32'(a_cnt), 32'd1);
    a_up = 0;
    #1 chk("dn_tc1", 32'(a_tc), 32'h0);
    cyc(); chk("dn_0", 32'(a_cnt), 32'd0); chk("dn_tc0", 32'(a_tc), 32'h1);
    cyc(); chk("dn_9", 32'(a_cnt), 32'd9); chk("dn_tc9", 32'(a_tc), 32'h0);

    // saturate from 7 up
    a_mode = 2'b01; a_up = 1; a_load = 1; a_din = 8'd7;
    cyc(); chk("sat_7", 32'(a_cnt), 32'd7);
    a_load = 0;
    cyc(); chk("sat_8",  32'(a_cnt), 32'd8);
    cyc(); chk("sat_9",  32'(a_cnt), 32'd9);
    cyc(); chk("sat_9b", 32'(a_cnt), 32'd9);
    cyc(); chk("sat_9c", 32'(a_cnt), 32'd9); chk("sat_tc", 32'(a_tc), 32'h1);
    chk("sat_done", 32'(a_done), 32'h0);

    // one-shot from 7
    a_mode = 2'b10; a_load = 1; a_din = 8'd7;
    cyc(); chk("os_7", 32'(a_cnt), 32'd7); chk("os_done7", 32'(a_done), 32'h0);
    a_load = 0;
    cyc(); chk("os_8", 32'(a_cnt), 32'd8); chk("os_done8", 32'(a_done), 32'h0);
    cyc(); chk("os_9", 32'(a_cnt), 32'd9); chk("os_done9", 32'(a_done), 32'h1);
    cyc(); chk("os_9b", 32'(a_cnt), 32'd9); chk("os_doneb", 32'(a_done), 32'h1);
    cyc(); chk("os_9c", 32'(a_cnt), 32'd9); chk("os_donec", 32'(a_done), 32'h1);
    a_load = 1; a_din = 8'd3;
    cyc(); chk("os_ld3", 32'(a_cnt), 32'd3); chk("os_clr", 32'(a_done), 32'h0);
    a_load = 0;
    cyc(); chk("os_4", 32'(a_cnt), 32'd4);

    // load clamp and priority over a step; load with cken=0
    a_mode = 2'b00; a_load = 1; a_din = 8'd200;
    cyc(); chk("clamp_9", 32'(a_cnt), 32'd9);
    a_cken = 0; a_din = 8'd2;
    cyc(); chk("ld_nocken", 32'(a_cnt), 32'd2);
    a_load = 0;
    cyc(); chk("hold_nocken", 32'(a_cnt), 32'd2);
    a_cken = 1;

    // store timing
    a_load = 1; a_din = 8'd5;
    cyc(); chk("st_ld5", 32'(a_cnt), 32'd5);
    a_load = 0; a_store = 1;
    cyc(); chk("st_cnt6", 32'(a_cnt), 32'd6); chk("st_data5", 32'(a_data), 32'd5);
    a_store = 0;
    cyc(); chk("st_cnt7", 32'(a_cnt), 32'd7); chk("st_hold7", 32'(a_data), 32'd5);
    cyc(); chk("st_hold8", 32'(a_data), 32'd5);
    a_store = 1; a_load = 1; a_din = 8'd2;
    cyc(); chk("st_ld_cnt", 32'(a_cnt), 32'd2); chk("st_ld_data", 32'(a_data), 32'd8);
    a_store = 0; a_load = 0;
    cyc(); chk("st_after_cnt", 32'(a_cnt), 32'd3); chk("st_after_data", 32'(a_data), 32'd8);

    // cascade 0x0F -> 0x10
    c0_cken = 1; c0_load = 1; c0_din = 4'hF; c1_load = 1; c1_din = 4'h0;
    cyc(); chk("cas_0f", 32'({c1_cnt, c0_cnt}), 32'h0F); chk("cas_rco", 32'(c0_rco), 32'h1);
    c0_load = 0; c1_load = 0;
    cyc(); chk("cas_10", 32'({c1_cnt, c0_cnt}), 32'h10);
    cyc(); chk("cas_11", 32'({c1_cnt, c0_cnt}), 32'h11);
    c0_load = 1; c0_din = 4'hE;
    cyc(); chk("cas_1e", 32'({c1_cnt, c0_cnt}), 32'h1E);
    c0_load = 0;
    cyc(); chk("cas_1f", 32'({c1_cnt, c0_cnt}), 32'h1F);
    cyc(); chk("cas_20", 32'({c1_cnt, c0_cnt}), 32'h20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
